counter_driver: RTL and testbench
=================================

# counter_driver

Command-side controller for the `counter` block. It accepts host commands over a valid/ready handshake and turns each one into the counter's single-cycle control strobes: `init`+`init_val`, `start` and `return_current_count`. For reads it samples `current_count` after a fixed latency and returns the value over a valid/ready response channel. It sits between a CPU/RoCC-style command source and one `counter` instance, replacing the hand-driven stimulus used in bring-up.

## Interface
- `xLen`, 64, data width of `init_val`, `current_count`, `cmd_data`, `rsp_data`.
- `READ_LAT`, 1, cycles from the end of the `return_current_count` strobe to the `current_count` sample; legal range 0..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (low = in reset).
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  driver can accept a command.
- `cmd_op`  in  2  command opcode: 0 INIT, 1 START, 2 READ, 3 illegal.
- `cmd_data`  in  xLen  INIT value; ignored for other opcodes.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  host accepts the response.
- `rsp_data`  out  xLen  sampled count for READ; 0 otherwise.
- `rsp_err`  out  1  response is for an illegal opcode.
- `ctr_init`  out  1  to counter `init`.
- `ctr_init_val`  out  xLen  to counter `init_val`.
- `ctr_start`  out  1  to counter `start`.
- `ctr_return_current_count`  out  1  to counter `return_current_count`.
- `ctr_current_count`  in  xLen  from counter `current_count`.
- `cmd_count`  out  16  number of accepted commands; wraps at 16 bits.

## Operation
- Reset (asynchronous on `reset` low) drives every output to 0, including `cmd_ready`, `ctr_init_val`, `rsp_data` and `cmd_count`. The FSM enters IDLE.
- FSM states: IDLE, STROBE, WAIT, RESP.
  - IDLE: `cmd_ready`=1. On `cmd_valid && cmd_ready`, latch `cmd_op`/`cmd_data`, increment `cmd_count`, and go to STROBE.
  - STROBE (exactly 1 cycle). The strobe driven depends on the opcode:
    - INIT: `ctr_init`=1; `ctr_init_val`=latched data.
    - START: `ctr_start`=1.
    - READ: `ctr_return_current_count`=1.
    - Illegal: no strobe.
  - From STROBE: READ with `READ_LAT`>0 goes to WAIT; READ with `READ_LAT`=0 samples `ctr_current_count` at the end of STROBE and goes to RESP; all other opcodes go to RESP.
  - WAIT: a 4-bit down-counter is loaded with `READ_LAT`. On reaching its final cycle, sample `ctr_current_count` into `rsp_data` and go to RESP.
  - RESP: `rsp_valid`=1. `rsp_data` is the sample (READ) or 0. `rsp_err`=1 only for opcode 3. The response holds stable until `rsp_valid && rsp_ready`, then the FSM returns to IDLE.
- `ctr_init_val` is a register. It keeps the last INIT value after the strobe and changes only on INIT.
- At most one command is in flight. No command is accepted outside IDLE.
- `cmd_count` wraps from 0xFFFF to 0x0000 with no flag.

## Timing
- `cmd_ready` is registered. It stays 0 during reset and rises on the first rising edge after `reset` goes high.
- Accept edge = T0. The strobe is high for the whole of cycle T0+1 and is never wider than one cycle. `cmd_ready`=0 from T0+1.
- INIT/START/illegal: `rsp_valid` rises in cycle T0+2.
- READ: the sample is taken at the edge ending cycle T0+1+`READ_LAT`, and `rsp_valid` rises in cycle T0+2+`READ_LAT`.
- Response accepted at edge Tr: `rsp_valid`=0 and `cmd_ready`=1 in cycle Tr+1. A new command can be accepted at edge Tr+1, giving a minimum 3-cycle command period for INIT/START.
- `cmd_valid` while not in IDLE is ignored and not counted. The host must hold `cmd_valid` until it sees `cmd_ready`.
- `reset` asserted mid-operation:
  - All strobes and `rsp_valid` drop immediately (asynchronously).
  - The in-flight command is discarded with no response.
  - `ctr_init_val` and `cmd_count` clear to 0.

## Test plan
- Reset release: hold `reset`=0 for 3 cycles, then release. Required: all outputs 0 while low; `cmd_ready`=1 from the first edge after release; `cmd_count`=0.
- INIT then START: INIT with `cmd_data`=75, then START, responding with `rsp_ready`=1. Required: `ctr_init`=1 for one cycle with `ctr_init_val`=75, which stays 75 afterwards; `ctr_start` pulses once; each `rsp_valid` comes 2 cycles after accept with `rsp_data`=0; `cmd_count`=2.
- READ latency: `READ_LAT`=1, with the counter model holding 75 for the whole command. Required: `ctr_return_current_count` is a 1-cycle pulse at T0+1; `rsp_valid` at T0+3 with `rsp_data`=75. Repeat with `READ_LAT`=0 and require `rsp_valid` at T0+2.
- Backpressure: hold `rsp_ready`=0 for 5 cycles on a READ while driving `cmd_valid`=1 with a new command. Required: `rsp_valid`/`rsp_data` stay stable; no second strobe; `cmd_count` increments only after the response is taken and the next accept occurs.
- Illegal op and wrap: issue `cmd_op`=3. Required: no strobe; `rsp_err`=1; `rsp_data`=0. Preload 0xFFFF accepted commands, then accept one more. Required: `cmd_count`=0x0000.
- Mid-operation reset: assert `reset`=0 during WAIT or RESP of a READ. Required: `rsp_valid`, strobes, `ctr_init_val` and `cmd_count` go to 0 immediately; no response after release; the next READ completes normally.

Source files
------------

// File: rtl/counter_driver.sv
// counter_driver: host command front-end for one counter block.
// Turns each accepted command into a one-cycle counter strobe.
module counter_driver #(
    parameter int xLen     = 64,
    parameter int READ_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [xLen-1:0] cmd_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [xLen-1:0] rsp_data,
    output logic            rsp_err,
    output logic            ctr_init,
    output logic [xLen-1:0] ctr_init_val,
    output logic            ctr_start,
    output logic            ctr_return_current_count,
    input  logic [xLen-1:0] ctr_current_count,
    output logic [15:0]     cmd_count
);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] OP_INIT  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_ILL   = 2'd3;

    localparam logic [3:0] LAT = 4'(READ_LAT);

    state_t     state;
    logic [1:0] op_q;
    logic [3:0] wait_cnt;

    // Command FSM; every output is a register cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                    <= IDLE;
            op_q                     <= OP_INIT;
            wait_cnt                 <= 4'd0;
            cmd_ready                <= 1'b0;
            rsp_valid                <= 1'b0;
            rsp_data                 <= '0;
            rsp_err                  <= 1'b0;
            ctr_init                 <= 1'b0;
            ctr_init_val             <= '0;
            ctr_start                <= 1'b0;
            ctr_return_current_count <= 1'b0;
            cmd_count                <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_q      <= cmd_op;
                        cmd_ready <= 1'b0;
                        cmd_count <= cmd_count + 16'd1;
                        ctr_init  <= (cmd_op == OP_INIT);
                        ctr_start <= (cmd_op == OP_START);
                        ctr_return_current_count <= (cmd_op == OP_READ);
                        if (cmd_op == OP_INIT) begin
                            ctr_init_val <= cmd_data;
                        end
                        state <= STROBE;
                    end
                end
                STROBE: begin
                    ctr_init                 <= 1'b0;
                    ctr_start                <= 1'b0;
                    ctr_return_current_count <= 1'b0;
                    if (op_q == OP_READ && LAT != 4'd0) begin
                        wait_cnt <= LAT;
                        state    <= WAIT;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= (op_q == OP_ILL);
                        if (op_q == OP_READ) begin
                            rsp_data <= ctr_current_count;
                        end else begin
                            rsp_data <= '0;
                        end
                        state <= RESP;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd1) begin
                        wait_cnt  <= 4'd0;
                        rsp_data  <= ctr_current_count;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_driver.sv
// tb_counter_driver: random and directed commands on two driver
// instances (read latency 1 and 0) against a transaction-level model.
`timescale 1ns/1ps
module tb_counter_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n;
    logic [1:0]       cmd_valid;
    logic [1:0]       cmd_ready;
    logic [1:0][1:0]  cmd_op;
    logic [1:0][63:0] cmd_data;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][63:0] rsp_data;
    logic [1:0]       rsp_err;
    logic [1:0]       ctr_init;
    logic [1:0][63:0] ctr_init_val;
    logic [1:0]       ctr_start;
    logic [1:0]       ctr_rcc;
    logic [1:0][63:0] ccount;
    logic [1:0][15:0] cmd_count;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        counter_driver #(
            .xLen(64),
            .READ_LAT((g == 0) ? 1 : 0)
        ) u_dut (
            .clk(clk),
            .reset(rst_n[g]),
            .cmd_valid(cmd_valid[g]),
            .cmd_ready(cmd_ready[g]),
            .cmd_op(cmd_op[g]),
            .cmd_data(cmd_data[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_data(rsp_data[g]),
            .rsp_err(rsp_err[g]),
            .ctr_init(ctr_init[g]),
            .ctr_init_val(ctr_init_val[g]),
            .ctr_start(ctr_start[g]),
            .ctr_return_current_count(ctr_rcc[g]),
            .ctr_current_count(ccount[g]),
            .cmd_count(cmd_count[g])
        );
    end

    int total = 0;
    int bad = 0;
    logic [15:0] m_cnt [2];
    logic [63:0] m_iv [2];
    bit hold75 = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [2:0] strobes(input int i);
        return {ctr_init[i], ctr_start[i], ctr_rcc[i]};
    endfunction

    function automatic logic [5:0] ctl(input int i);
        return {cmd_ready[i], rsp_valid[i], rsp_err[i], strobes(i)};
    endfunction

    // One full command: accept, strobe, response latency, backpressure.
    task automatic do_cmd(input int i, input logic [1:0] op,
                          input logic [63:0] data, input int hold,
                          input bit keep, input logic [1:0] nop,
                          input logic [63:0] ndata);
        logic [63:0] vals [8];
        logic [63:0] want;
        int lat;
        int last;
        int n;
        lat = (i == 0) ? 1 : 0;
        cmd_valid[i] = 1'b1;
        cmd_op[i] = op;
        cmd_data[i] = data;
        n = 0;
        while (cmd_ready[i] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept", 64'(n < 20), 64'd1);
        if (n >= 20) begin
            cmd_valid[i] = 1'b0;
            return;
        end
        m_cnt[i] = m_cnt[i] + 16'd1;
        if (op == 2'd0) m_iv[i] = data;
        last = (op == 2'd2) ? 2 + lat : 2;
        for (int c = 0; c < 8; c++) vals[c] = 64'd0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            vals[c] = hold75 ? 64'd75 : {$urandom, $urandom};
            ccount[i] = vals[c];
            if (c == 1) begin
                if (keep) begin
                    cmd_op[i] = nop;
                    cmd_data[i] = ndata;
                end else begin
                    cmd_valid[i] = 1'b0;
                end
                check_eq("strobe", 64'(strobes(i)),
                         64'({op == 2'd0, op == 2'd1, op == 2'd2}));
                check_eq("ready_lo", 64'(cmd_ready[i]), 64'd0);
                check_eq("count", 64'(cmd_count[i]), 64'(m_cnt[i]));
                check_eq("init_val", ctr_init_val[i], m_iv[i]);
                check_eq("rsp_early", 64'(rsp_valid[i]), 64'd0);
            end else if (c < last) begin
                check_eq("strobe_off", 64'(strobes(i)), 64'd0);
                check_eq("rsp_early", 64'(rsp_valid[i]), 64'd0);
            end
        end
        want = (op == 2'd2) ? vals[1 + lat] : 64'd0;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
                @(negedge clk);
                if (!hold75) ccount[i] = {$urandom, $urandom};
            end
            check_eq("rsp_valid", 64'(rsp_valid[i]), 64'd1);
            check_eq("rsp_data", rsp_data[i], want);
            check_eq("rsp_err", 64'(rsp_err[i]), 64'(op == 2'd3));
            check_eq("strobe_off", 64'(strobes(i)), 64'd0);
            check_eq("count_hold", 64'(cmd_count[i]), 64'(m_cnt[i]));
            check_eq("ready_busy", 64'(cmd_ready[i]), 64'd0);
            if (h == hold) rsp_ready[i] = 1'b1;
        end
        @(negedge clk);
        rsp_ready[i] = 1'b0;
        check_eq("rsp_drop", 64'(rsp_valid[i]), 64'd0);
        check_eq("ready_back", 64'(cmd_ready[i]), 64'd1);
        check_eq("init_keep", ctr_init_val[i], m_iv[i]);
    endtask

    // READ interrupted by reset after at_c cycles past accept.
    task automatic read_reset(input int i, input int at_c);
        int n;
        cmd_valid[i] = 1'b1;
        cmd_op[i] = 2'd2;
        cmd_data[i] = 64'd0;
        n = 0;
        while (cmd_ready[i] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept", 64'(n < 20), 64'd1);
        if (n >= 20) begin
            cmd_valid[i] = 1'b0;
            return;
        end
        for (int c = 1; c <= at_c; c++) begin
            @(negedge clk);
            ccount[i] = {$urandom, $urandom};
            if (c == 1) cmd_valid[i] = 1'b0;
        end
        #1 rst_n[i] = 1'b0;
        #1;
        m_cnt[i] = 16'd0;
        m_iv[i] = 64'd0;
        check_eq("rst_ctl", 64'(ctl(i)), 64'd0);
        check_eq("rst_data", rsp_data[i], 64'd0);
        check_eq("rst_iv", ctr_init_val[i], 64'd0);
        check_eq("rst_cnt", 64'(cmd_count[i]), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n[i] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq("no_rsp", 64'(rsp_valid[i]), 64'd0);
            check_eq("no_strobe", 64'(strobes(i)), 64'd0);
            check_eq("ready_rel", 64'(cmd_ready[i]), 64'd1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 2'b00;
        cmd_valid = '0;
        cmd_op = '0;
        cmd_data = '0;
        rsp_ready = '0;
        ccount = '0;
        m_cnt[0] = 16'd0;
        m_cnt[1] = 16'd0;
        m_iv[0] = 64'd0;
        m_iv[1] = 64'd0;

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check_eq("rst_ctl", 64'(ctl(i)), 64'd0);
                check_eq("rst_data", rsp_data[i], 64'd0);
                check_eq("rst_iv", ctr_init_val[i], 64'd0);
                check_eq("rst_cnt", 64'(cmd_count[i]), 64'd0);
            end
        end
        rst_n = 2'b11;
        #1;
        check_eq("ready_pre", 64'(cmd_ready[0]), 64'd0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("ready_up", 64'(cmd_ready[i]), 64'd1);
            check_eq("cnt_up", 64'(cmd_count[i]), 64'd0);
        end

        do_cmd(0, 2'd0, 64'd75, 0, 1'b0, 2'd0, 64'd0);
        do_cmd(0, 2'd1, 64'd9, 0, 1'b0, 2'd0, 64'd0);
        check_eq("cnt2", 64'(cmd_count[0]), 64'd2);
        check_eq("iv75", ctr_init_val[0], 64'd75);

        hold75 = 1'b1;
        do_cmd(0, 2'd2, 64'd0, 0, 1'b0, 2'd0, 64'd0);
        do_cmd(1, 2'd2, 64'd0, 0, 1'b0, 2'd0, 64'd0);
        hold75 = 1'b0;

        do_cmd(0, 2'd2, 64'd0, 5, 1'b1, 2'd1, 64'd5);
        do_cmd(0, 2'd1, 64'd5, 0, 1'b0, 2'd0, 64'd0);

        do_cmd(1, 2'd3, 64'hDEAD_BEEF, 1, 1'b0, 2'd0, 64'd0);

        force gen_dut[1].u_dut.cmd_count = 16'hFFFF;
        @(negedge clk);
        release gen_dut[1].u_dut.cmd_count;
        m_cnt[1] = 16'hFFFF;
        #1;
        check_eq("preload", 64'(cmd_count[1]), 64'hFFFF);
        do_cmd(1, 2'd3, 64'd1, 0, 1'b0, 2'd0, 64'd0);
        check_eq("wrap", 64'(cmd_count[1]), 64'd0);

        for (int i = 0; i < 2; i++) begin
            logic [1:0]  op;
            logic [1:0]  nop;
            logic [63:0] d;
            logic [63:0] nd;
            bit          keep;
            op = 2'($urandom_range(0, 3));
            d = {$urandom, $urandom};
            for (int k = 0; k < 30; k++) begin
                nop = 2'($urandom_range(0, 3));
                nd = {$urandom, $urandom};
                keep = 1'($urandom_range(0, 1));
                if (k == 29) keep = 1'b0;
                do_cmd(i, op, d, int'($urandom_range(0, 3)), keep, nop, nd);
                op = nop;
                d = nd;
            end
        end

        do_cmd(0, 2'd0, 64'h1234, 0, 1'b0, 2'd0, 64'd0);
        read_reset(0, 2);
        do_cmd(0, 2'd2, 64'd0, 1, 1'b0, 2'd0, 64'd0);
        do_cmd(0, 2'd0, 64'h55, 0, 1'b0, 2'd0, 64'd0);
        read_reset(0, 3);
        do_cmd(0, 2'd2, 64'd0, 0, 1'b0, 2'd0, 64'd0);
        read_reset(1, 2);
        do_cmd(1, 2'd2, 64'd0, 2, 1'b0, 2'd0, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
